// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master: FSM states, response
// status codes and the counter width helper.
package wb_cmd_master_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_BACKOFF,
      S_RSP
   } state_t;

   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_BUS_ERR   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT   = 2'b10;
   localparam logic [1:0] ST_RETRY_EXH = 2'b11;

   // Bits needed to hold 0..max_val; never narrower than one bit so a
   // disabled (zero) limit still yields a legal vector.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Pipelined Wishbone B4 initiator: turns a valid/ready command stream into
// single bus cycles, one outstanding at a time, with timeout and retry
// handling, and reports data plus status on a valid/ready response stream.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255,
   parameter int MAX_RETRY  = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,

   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
   input  logic [31:0]           cmd_dat_i,
   input  logic [3:0]            cmd_sel_i,

   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_dat_o,
   output logic [1:0]            rsp_status_o,

   output logic                  busy_o,

   output logic                  wb_cyc_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [3:0]            wb_sel_o,
   output logic [31:0]           wb_dat_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i,
   input  logic                  wb_stall_i,
   input  logic [31:0]           wb_dat_i
);

   localparam int TW = cnt_width(TIMEOUT);
   localparam int RW = cnt_width(MAX_RETRY);

   state_t          state;
   logic [TW-1:0]   tmo_cnt;
   logic [RW-1:0]   retry_cnt;

   logic            in_flight;
   logic            resp_seen;
   logic [TW-1:0]   tmo_next;
   logic            tmo_hit;
   logic            fin;
   logic [1:0]      fin_status;
   logic [31:0]     fin_dat;
   logic            do_retry;

   assign busy_o = (state != S_IDLE);

   // Decode what the bus did this cycle: a response only counts once the
   // strobe has been taken (same edge in REQ, or any time in WAIT), and the
   // timeout fires only when no response arrives on the limit cycle.
   always_comb begin
      in_flight  = (state == S_REQ) || (state == S_WAIT);
      resp_seen  = in_flight && ((state == S_WAIT) || !wb_stall_i)
                   && (wb_err_i || wb_rty_i || wb_ack_i);
      tmo_next   = tmo_cnt + TW'(1);
      tmo_hit    = (TIMEOUT != 0) && (tmo_next == TW'(TIMEOUT));
      fin        = 1'b0;
      fin_status = ST_OK;
      fin_dat    = 32'h0;
      do_retry   = 1'b0;
      if (resp_seen) begin
         if (wb_err_i) begin
            fin        = 1'b1;
            fin_status = ST_BUS_ERR;
         end else if (wb_rty_i) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
               do_retry = 1'b1;
            end else begin
               fin        = 1'b1;
               fin_status = ST_RETRY_EXH;
            end
         end else begin
            fin        = 1'b1;
            fin_status = ST_OK;
            fin_dat    = wb_we_o ? 32'h0 : wb_dat_i;
         end
      end else if (in_flight && tmo_hit) begin
         fin        = 1'b1;
         fin_status = ST_TIMEOUT;
      end
   end

   // Command/bus/response state machine with all outputs registered.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= S_IDLE;
         tmo_cnt      <= '0;
         retry_cnt    <= '0;
         cmd_ready_o  <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_dat_o    <= 32'h0;
         rsp_status_o <= ST_OK;
         wb_cyc_o     <= 1'b0;
         wb_stb_o     <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_adr_o     <= '0;
         wb_sel_o     <= 4'h0;
         wb_dat_o     <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               cmd_ready_o <= 1'b1;
               if (cmd_valid_i && cmd_ready_o) begin
                  wb_we_o     <= cmd_we_i;
                  wb_adr_o    <= cmd_adr_i;
                  wb_dat_o    <= cmd_dat_i;
                  wb_sel_o    <= cmd_sel_i;
                  retry_cnt   <= '0;
                  tmo_cnt     <= '0;
                  wb_cyc_o    <= 1'b1;
                  wb_stb_o    <= 1'b1;
                  cmd_ready_o <= 1'b0;
                  state       <= S_REQ;
               end
            end
            S_REQ, S_WAIT: begin
               if (fin) begin
                  wb_cyc_o     <= 1'b0;
                  wb_stb_o     <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  rsp_status_o <= fin_status;
                  rsp_dat_o    <= fin_dat;
                  state        <= S_RSP;
               end else if (do_retry) begin
                  retry_cnt <= retry_cnt + RW'(1);
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  state     <= S_BACKOFF;
               end else begin
                  if ((state == S_REQ) && !wb_stall_i) begin
                     wb_stb_o <= 1'b0;
                     state    <= S_WAIT;
                  end
                  if (tmo_cnt != '1) begin
                     tmo_cnt <= tmo_next;
                  end
               end
            end
            S_BACKOFF: begin
               tmo_cnt  <= '0;
               wb_cyc_o <= 1'b1;
               wb_stb_o <= 1'b1;
               state    <= S_REQ;
            end
            S_RSP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               wb_cyc_o    <= 1'b0;
               wb_stb_o    <= 1'b0;
               rsp_valid_o <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed testbench for wb_cmd_master with a hand-driven Wishbone slave.
module tb_wb_cmd_master;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic [15:0] cmd_adr_i = 16'h0;
   logic [31:0] cmd_dat_i = 32'h0;
   logic [3:0]  cmd_sel_i = 4'h0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic        busy_o;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [15:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
   logic [31:0] wb_dat_i = 32'h0;

   int errors = 0;
   int checks = 0;
   int stb_acc = 0;
   int rsp_hs = 0;

   wb_cmd_master #(.ADDR_WIDTH(16), .TIMEOUT(8), .MAX_RETRY(3)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
      .rsp_status_o(rsp_status_o), .busy_o(busy_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
      .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk_i = ~clk_i;

   // Count accepted strobes and response handshakes seen at each edge.
   always @(posedge clk_i) begin
      if (wb_cyc_o && wb_stb_o && !wb_stall_i) stb_acc++;
      if (rsp_valid_o && rsp_ready_i) rsp_hs++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_cmd(input logic we, input logic [15:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
      int waited = 0;
      while (!cmd_ready_o && waited < 20) begin
         tick();
         waited++;
      end
      checks++;
      if (!cmd_ready_o) begin
         errors++;
         $display("[TB] FAIL cmd_ready_wait: cmd_ready=%0b required 1 within 20 cycles", cmd_ready_o);
      end
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_sel_i   = sel;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic consume_rsp();
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i = 1'b0;
      #3;
      checks++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o, busy_o} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b required 00000", {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o, busy_o});
      end
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
      tick();
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_idle: ready=%0b busy=%0b required ready=1 busy=0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_write_stall();
      wb_stall_i = 1'b1;
      stb_acc = 0;
      send_cmd(1'b1, 16'h0000, 32'h0000_00F0, 4'hF);
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111 || wb_dat_o !== 32'h0000_00F0 || wb_sel_o !== 4'hF) begin
         errors++;
         $display("[TB] FAIL write_req: cyc/stb/we=%b dat=%h sel=%h required 111 000000f0 f", {wb_cyc_o, wb_stb_o, wb_we_o}, wb_dat_o, wb_sel_o);
      end
      tick();
      tick();
      checks++;
      if (wb_stb_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_stall_hold: stb=%0b required 1", wb_stb_o);
      end
      wb_stall_i = 1'b0;
      wb_ack_i   = 1'b1;
      tick();
      wb_ack_i   = 1'b0;
      checks++;
      if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_done: cyc=%0b rsp_valid=%0b required 0 1", wb_cyc_o, rsp_valid_o);
      end
      checks++;
      if (rsp_status_o !== 2'b00 || rsp_dat_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL write_rsp: status=%b dat=%h required 00 00000000", rsp_status_o, rsp_dat_o);
      end
      checks++;
      if (stb_acc !== 1) begin
         errors++;
         $display("[TB] FAIL write_stb_count: got %0d required 1", stb_acc);
      end
      consume_rsp();
      checks++;
      if (rsp_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_rsp_clear: rsp_valid=%0b required 0", rsp_valid_o);
      end
   endtask

   task automatic test_read_hold();
      send_cmd(1'b0, 16'h0000, 32'h0, 4'hF);
      tick();
      checks++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_wait: cyc=%0b stb=%0b required 1 0", wb_cyc_o, wb_stb_o);
      end
      tick();
      tick();
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h0000_0512;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0000_0512 || rsp_status_o !== 2'b00) begin
         errors++;
         $display("[TB] FAIL read_rsp: valid=%0b dat=%h status=%b required 1 00000512 00", rsp_valid_o, rsp_dat_o, rsp_status_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h0000_0512 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_hold_%0d: valid=%0b dat=%h ready=%0b required 1 00000512 0", i, rsp_valid_o, rsp_dat_o, cmd_ready_o);
         end
      end
      consume_rsp();
      checks++;
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL read_next_ready: valid=%0b ready=%0b required 0 1", rsp_valid_o, cmd_ready_o);
      end
   endtask

   task automatic test_retry();
      stb_acc = 0;
      send_cmd(1'b0, 16'h0040, 32'h0, 4'hF);
      for (int a = 0; a < 2; a++) begin
         wb_rty_i = 1'b1;
         tick();
         wb_rty_i = 1'b0;
         checks++;
         if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL retry_backoff_%0d: cyc=%0b rsp_valid=%0b required 0 0", a, wb_cyc_o, rsp_valid_o);
         end
         tick();
         checks++;
         if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL retry_reissue_%0d: cyc=%0b stb=%0b required 1 1", a, wb_cyc_o, wb_stb_o);
         end
      end
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hA5A5_0001;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00 || rsp_dat_o !== 32'hA5A5_0001) begin
         errors++;
         $display("[TB] FAIL retry_ok: valid=%0b status=%b dat=%h required 1 00 a5a50001", rsp_valid_o, rsp_status_o, rsp_dat_o);
      end
      checks++;
      if (stb_acc !== 3) begin
         errors++;
         $display("[TB] FAIL retry_stb_count: got %0d required 3", stb_acc);
      end
      consume_rsp();
   endtask

   task automatic test_retry_exhaust();
      stb_acc = 0;
      send_cmd(1'b1, 16'h0044, 32'h1111_2222, 4'h3);
      for (int a = 0; a < 3; a++) begin
         wb_rty_i = 1'b1;
         tick();
         wb_rty_i = 1'b0;
         tick();
      end
      checks++;
      if (rsp_valid_o !== 1'b0 || wb_stb_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL exhaust_early: rsp_valid=%0b stb=%0b required 0 1", rsp_valid_o, wb_stb_o);
      end
      wb_rty_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b11 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL exhaust_rsp: valid=%0b status=%b cyc=%0b required 1 11 0", rsp_valid_o, rsp_status_o, wb_cyc_o);
      end
      checks++;
      if (stb_acc !== 4) begin
         errors++;
         $display("[TB] FAIL exhaust_stb_count: got %0d required 4", stb_acc);
      end
      consume_rsp();
   endtask

   task automatic test_timeout();
      int high = 1;
      rsp_hs = 0;
      send_cmd(1'b0, 16'h0080, 32'h0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!wb_cyc_o) break;
         high++;
      end
      checks++;
      if (high !== 8) begin
         errors++;
         $display("[TB] FAIL timeout_cycles: cyc high %0d cycles required 8", high);
      end
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b10 || rsp_dat_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL timeout_rsp: valid=%0b status=%b dat=%h required 1 10 00000000", rsp_valid_o, rsp_status_o, rsp_dat_o);
      end
      tick();
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hBAD0_BAD0;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      checks++;
      if (rsp_status_o !== 2'b10 || rsp_dat_o !== 32'h0 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_late_ack: status=%b dat=%h cyc=%0b required 10 00000000 0", rsp_status_o, rsp_dat_o, wb_cyc_o);
      end
      consume_rsp();
      tick();
      tick();
      tick();
      checks++;
      if (rsp_hs !== 1 || rsp_valid_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_single_rsp: handshakes=%0d valid=%0b required 1 0", rsp_hs, rsp_valid_o);
      end
   endtask

   task automatic test_err_ack();
      send_cmd(1'b0, 16'h0010, 32'h0, 4'hF);
      wb_err_i = 1'b1;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hDEAD_BEEF;
      tick();
      wb_err_i = 1'b0;
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b01 || rsp_dat_o !== 32'h0) begin
         errors++;
         $display("[TB] FAIL err_ack: valid=%0b status=%b dat=%h required 1 01 00000000", rsp_valid_o, rsp_status_o, rsp_dat_o);
      end
      consume_rsp();
   endtask

   task automatic test_reset_midflight();
      rsp_hs = 0;
      send_cmd(1'b0, 16'h0020, 32'h0, 4'hF);
      tick();
      checks++;
      if (wb_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_wait: cyc=%0b busy=%0b required 1 1", wb_cyc_o, busy_o);
      end
      #1;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, rsp_valid_o} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL midreset_async: cyc/stb/rsp_valid=%b required 000", {wb_cyc_o, wb_stb_o, rsp_valid_o});
      end
      tick();
      rst_n_i = 1'b1;
      tick();
      tick();
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || rsp_hs !== 0) begin
         errors++;
         $display("[TB] FAIL midreset_idle: ready=%0b busy=%0b handshakes=%0d required 1 0 0", cmd_ready_o, busy_o, rsp_hs);
      end
      send_cmd(1'b0, 16'h0024, 32'h0, 4'hF);
      checks++;
      if (wb_adr_o !== 16'h0024 || wb_we_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_req: adr=%h we=%0b required 0024 0", wb_adr_o, wb_we_o);
      end
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h1234_5678;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'b00 || rsp_dat_o !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL midreset_read: valid=%0b status=%b dat=%h required 1 00 12345678", rsp_valid_o, rsp_status_o, rsp_dat_o);
      end
      consume_rsp();
   endtask

   // Run each scenario in order, then report.
   initial begin
      test_reset();
      test_write_stall();
      test_read_hold();
      test_retry();
      test_retry_exhaust();
      test_timeout();
      test_err_ack();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
